// File: rtl/neuron_sample_feeder.sv
// Sample store and streaming source for NeuronModule training runs.
// Optional FEEDER_EPOCH_LIMIT_EN adds an ABORT state and a timeout output after MAX_EPOCHS passes.
module neuron_sample_feeder #(
  parameter int DEPTH      = 8,
  parameter int X_W        = 7,
  parameter int T_W        = 2,
  parameter int N_W        = 32,
  parameter int MAX_EPOCHS = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrEn,
  input  logic signed [X_W-1:0] wrX1,
  input  logic signed [X_W-1:0] wrX2,
  input  logic signed [T_W-1:0] wrT,
  input  logic                  clear,
  input  logic                  runReq,
  output logic                  start,
  output logic signed [X_W-1:0] X1Bus,
  output logic signed [X_W-1:0] X2Bus,
  output logic signed [T_W-1:0] tBus,
  output logic [N_W-1:0]        nBus,
  input  logic                  readyToGetData,
  input  logic                  updateState,
  input  logic                  reinitializingState,
  input  logic                  done,
  output logic                  busy,
  output logic                  finished,
  output logic [15:0]           epochCount,
  output logic                  loadOverflow,
`ifdef FEEDER_EPOCH_LIMIT_EN
  output logic                  timeout,
`endif
  output logic                  emptyErr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    STREAM   = 3'd2,
    FINISHED = 3'd3,
    ABORT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic signed [X_W-1:0] x1_mem [DEPTH];
  logic signed [X_W-1:0] x2_mem [DEPTH];
  logic signed [T_W-1:0] t_mem  [DEPTH];

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] eff_count;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] idx_nxt;
  logic             st_cnt;
  logic             idle_like, wr_ok, ovf_set, run_ok, adv, wrap, limit_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idle_like = (state == IDLE) || (state == FINISHED) || (state == ABORT);
  assign wr_ok     = idle_like && wrEn && !clear && (count != CNT_W'(DEPTH));
  assign ovf_set   = idle_like && wrEn && !clear && (count == CNT_W'(DEPTH));
  // Count the run will see: clear empties first, a same-cycle write lands before runReq.
  assign eff_count = clear ? '0 : (wr_ok ? count + 1'b1 : count);
  assign run_ok    = idle_like && runReq && (eff_count != '0);

  assign adv     = (state == STREAM) && readyToGetData && !updateState
                   && !reinitializingState && !done;
  assign wrap    = (CNT_W'(index) == count - 1'b1);
  assign idx_nxt = wrap ? '0 : index + 1'b1;

`ifdef FEEDER_EPOCH_LIMIT_EN
  assign limit_hit = adv && wrap && (sat_inc(epochCount) >= 16'(MAX_EPOCHS));
  assign timeout   = (state == ABORT);
`else
  logic unused_lim;
  assign limit_hit  = 1'b0;
  assign unused_lim = ^16'(MAX_EPOCHS);
`endif

  assign start = (state == START);
  assign busy  = (state == START) || (state == STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:            if (run_ok) state_nxt = START;
      START:           if (st_cnt) state_nxt = STREAM;
      STREAM: begin
        if (done)           state_nxt = FINISHED;
        else if (limit_hit) state_nxt = ABORT;
      end
      FINISHED, ABORT: begin
        if (run_ok)     state_nxt = START;
        else if (clear) state_nxt = IDLE;
      end
      default:         state_nxt = IDLE;
    endcase
  end

  // Sample store: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      x1_mem[count[IDX_W-1:0]] <= wrX1;
      x2_mem[count[IDX_W-1:0]] <= wrX2;
      t_mem[count[IDX_W-1:0]]  <= wrT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      index        <= '0;
      st_cnt       <= 1'b0;
      loadOverflow <= 1'b0;
      emptyErr     <= 1'b0;
      finished     <= 1'b0;
      epochCount   <= '0;
      nBus         <= '0;
      X1Bus        <= '0;
      X2Bus        <= '0;
      tBus         <= '0;
    end else begin
      st_cnt   <= (state == START) ? ~st_cnt : 1'b0;
      emptyErr <= idle_like && runReq && (eff_count == '0);
      if (idle_like && clear) begin
        count        <= '0;
        loadOverflow <= 1'b0;
        finished     <= 1'b0;
      end else begin
        if (wr_ok)   count        <= count + 1'b1;
        if (ovf_set) loadOverflow <= 1'b1;
      end
      if (run_ok) begin
        index      <= '0;
        epochCount <= '0;
        finished   <= 1'b0;
        nBus       <= N_W'(eff_count);
        // Slot 0 may be written in this same cycle, so forward the write data.
        X1Bus      <= (wr_ok && count == '0) ? wrX1 : x1_mem[0];
        X2Bus      <= (wr_ok && count == '0) ? wrX2 : x2_mem[0];
        tBus       <= (wr_ok && count == '0) ? wrT  : t_mem[0];
      end
      if (state == STREAM && done) begin
        finished <= 1'b1;
      end else if (adv) begin
        index <= idx_nxt;
        X1Bus <= x1_mem[idx_nxt];
        X2Bus <= x2_mem[idx_nxt];
        tBus  <= t_mem[idx_nxt];
        if (wrap) epochCount <= sat_inc(epochCount);
      end
    end
  end

endmodule
